// File: rtl/vga_rx_decoder_if.sv
// Signal bundle between a VGA timing source and the receive-side decoder.
// The master drives the sampled video; the slave returns the decoded pixel stream.
interface vga_rx_decoder_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [7:0] color_out;
  logic       pixel_valid;
  logic       frame_start;
  logic       locked;
  logic       h_err;
  logic       v_err;

  modport master (
    output pix_en, hsync, vsync, blank_n, red, green, blue,
    input  pixel_x, pixel_y, color_out, pixel_valid, frame_start, locked, h_err, v_err
  );

  modport slave (
    input  pix_en, hsync, vsync, blank_n, red, green, blue,
    output pixel_x, pixel_y, color_out, pixel_valid, frame_start, locked, h_err, v_err
  );
endinterface

// File: rtl/vga_rx_decoder.sv
// On-chip VGA frame checker: recovers pixel coordinates and packed colour from
// sync/blank/RGB, checks line and frame timing, and reports lock.
module vga_rx_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int LOCK_FRAMES = 2
) (
  input logic             clk,
  input logic             rst,
  vga_rx_decoder_if.slave bus
);

  localparam int GW = $clog2(LOCK_FRAMES + 1) + 1;

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
    return {r[7:5], g[7:5], b[7:6]};
  endfunction

  state_t         r_state, w_state_nxt;
  logic [GW-1:0]  r_good, w_good_nxt;
  logic           r_hs_p1, r_vs_p1, r_bl_p1, r_vld_p1;
  logic           r_hs_p2, r_vs_p2, r_vld_p2;
  logic [7:0]     r_col_p1;
  logic [9:0]     r_h_cnt, r_v_cnt, r_vs_w, r_xcnt, r_ycnt;
  logic           r_h_arm, r_hlow_seen, r_h_to, r_vlow_seen, r_ferr, r_line_act;
  logic [9:0]     r_pixel_x;
  logic [7:0]     r_color;
  logic           r_pvld, r_fs, r_herr, r_verr;

  logic           w_edge_ok, w_hfall, w_hrise, w_vfall, w_vrise;
  logic [10:0]    w_h_inc, w_v_tot;
  logic           w_herr, w_verr, w_err;
  logic [9:0]     w_xcol, w_yrow;
  logic           w_unused;

  assign w_unused = ^{bus.red[4:0], bus.green[4:0], bus.blue[5:0]};

  // Stage 1 -> edge detect: stage 1 against its previous value
  assign w_edge_ok = r_vld_p1 & r_vld_p2;
  assign w_hfall   = w_edge_ok &  r_hs_p2 & ~r_hs_p1;
  assign w_hrise   = w_edge_ok & ~r_hs_p2 &  r_hs_p1;
  assign w_vfall   = w_edge_ok &  r_vs_p2 & ~r_vs_p1;
  assign w_vrise   = w_edge_ok & ~r_vs_p2 &  r_vs_p1;

  assign w_h_inc = {1'b0, r_h_cnt} + 11'd1;
  // A coincident hsync fall closes the old frame rather than opening the new one
  assign w_v_tot = {1'b0, r_v_cnt} + {10'd0, w_hfall};

  assign w_herr = (w_hfall & r_h_arm & (w_h_inc != 11'(H_TOTAL)))
                | (w_hrise & r_hlow_seen & (w_h_inc != 11'(H_SYNC)))
                | (~w_hfall & ~r_h_to & (r_h_cnt == 10'h3FF));
  assign w_verr = (w_vfall & (r_state != S_SEARCH) & (w_v_tot != 11'(V_TOTAL)))
                | (w_vrise & r_vlow_seen & (r_vs_w != 10'(V_SYNC)));
  assign w_err  = w_herr | w_verr;

  assign w_xcol = w_hfall ? 10'd0 : r_xcnt;
  assign w_yrow = w_vfall ? 10'd0 :
                  (w_hfall & r_line_act) ? sat_inc(r_ycnt) : r_ycnt;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      S_SEARCH: begin
        if (w_vfall) begin
          w_state_nxt = S_MEASURE;
          w_good_nxt  = '0;
        end
      end
      S_MEASURE: begin
        if (w_err) begin
          w_good_nxt = '0;
        end else if (w_vfall && !r_ferr) begin
          if (r_good + GW'(1) == GW'(LOCK_FRAMES)) begin
            w_state_nxt = S_LOCKED;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt = r_good + GW'(1);
          end
        end
      end
      S_LOCKED: begin
        if (w_err) begin
          w_state_nxt = S_MEASURE;
          w_good_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_SEARCH;
        w_good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.pix_en) r_col_p1 <= pack_rgb(bus.red, bus.green, bus.blue);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_SEARCH;   r_good <= '0;
      r_hs_p1 <= 1'b0;       r_vs_p1 <= 1'b0;    r_bl_p1 <= 1'b0;    r_vld_p1 <= 1'b0;
      r_hs_p2 <= 1'b0;       r_vs_p2 <= 1'b0;    r_vld_p2 <= 1'b0;
      r_h_cnt <= '0;         r_v_cnt <= '0;      r_vs_w <= '0;
      r_xcnt <= '0;          r_ycnt <= '0;
      r_h_arm <= 1'b0;       r_hlow_seen <= 1'b0; r_h_to <= 1'b0;
      r_vlow_seen <= 1'b0;   r_ferr <= 1'b0;     r_line_act <= 1'b0;
      r_pixel_x <= '0;       r_color <= '0;
      r_pvld <= 1'b0;        r_fs <= 1'b0;       r_herr <= 1'b0;     r_verr <= 1'b0;
    end else if (bus.pix_en) begin
      r_hs_p1  <= bus.hsync;
      r_vs_p1  <= bus.vsync;
      r_bl_p1  <= bus.blank_n;
      r_vld_p1 <= 1'b1;
      // Stage 1 -> stage 2: previous sample, counters and registered outputs
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_vld_p2 <= r_vld_p1;
      r_state  <= w_state_nxt;
      r_good   <= w_good_nxt;

      r_h_cnt     <= w_hfall ? 10'd0 : sat_inc(r_h_cnt);
      r_h_arm     <= r_h_arm | w_hfall;
      r_hlow_seen <= w_hfall | (r_hlow_seen & ~w_hrise);
      r_h_to      <= ~w_hfall & (r_h_to | (r_h_cnt == 10'h3FF));

      if (w_vfall)      r_v_cnt <= 10'd0;
      else if (w_hfall) r_v_cnt <= sat_inc(r_v_cnt);
      r_vlow_seen <= w_vfall | (r_vlow_seen & ~w_vrise);
      if (w_vfall)                 r_vs_w <= {9'd0, w_hfall};
      else if (w_hfall & ~r_vs_p1) r_vs_w <= sat_inc(r_vs_w);
      r_ferr <= ~w_vfall & (r_ferr | w_err);

      r_xcnt     <= r_bl_p1 ? sat_inc(w_xcol) : w_xcol;
      r_line_act <= r_bl_p1 | (~w_hfall & r_line_act);
      r_ycnt     <= w_yrow;

      r_pixel_x <= w_xcol;
      r_color   <= r_col_p1;
      r_pvld    <= r_bl_p1 & (w_state_nxt == S_LOCKED);
      r_fs      <= w_vfall;
      r_herr    <= w_herr;
      r_verr    <= w_verr;
    end
  end

  assign bus.pixel_x     = r_pixel_x;
  assign bus.pixel_y     = r_ycnt;
  assign bus.color_out   = r_color;
  assign bus.pixel_valid = r_pvld;
  assign bus.frame_start = r_fs;
  assign bus.locked      = (r_state == S_LOCKED);
  assign bus.h_err       = r_herr;
  assign bus.v_err       = r_verr;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder using a scaled-down 40x20 raster
// (24x12 active, hsync at 28..31, vsync on lines 14..15), pix_en every other clk.
module tb_vga_rx_decoder;
  localparam int HT = 40, HS = 4, VT = 20, VS = 2;
  localparam int HA = 24, VA = 12, HSB = 28, VSB = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_rx_decoder_if bus();

  vga_rx_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_herr, n_verr, n_fs;
  int prev_l = -1, prev_h = -1;
  bit lock_seen;
  int lock_l, lock_h;
  logic herr_lk, verr_lk;
  logic [9:0] x0, y0, x1, y1;
  logic [7:0] c0, cb;
  logic v0, v1, vb;

  task automatic clear_counts();
    n_herr = 0; n_verr = 0; n_fs = 0;
    lock_seen = 1'b0; lock_l = -1; lock_h = -1;
    herr_lk = 1'bx; verr_lk = 1'bx;
  endtask

  // One pixel strobe; afterwards the outputs describe the previous sample.
  task automatic send_px(input int l, input int h, input bit stuck);
    logic act;
    act = (h < HA) && (l < VA);
    bus.hsync   = (stuck || (h >= HSB && h < HSB + HS)) ? 1'b0 : 1'b1;
    bus.vsync   = (l >= VSB && l < VSB + VS) ? 1'b0 : 1'b1;
    bus.blank_n = act;
    bus.red     = act ? 8'hE0 : 8'h00;
    bus.green   = act ? 8'h1F : 8'h00;
    bus.blue    = act ? 8'hC0 : 8'h00;
    bus.pix_en  = 1'b1;
    @(posedge clk); #1;
    bus.pix_en  = 1'b0;
    @(posedge clk); #1;
    if (bus.h_err) begin n_herr++; herr_lk = bus.locked; end
    if (bus.v_err) begin n_verr++; verr_lk = bus.locked; end
    if (bus.frame_start) n_fs++;
    if (bus.locked && !lock_seen) begin lock_seen = 1'b1; lock_l = prev_l; lock_h = prev_h; end
    if (prev_l == 0 && prev_h == 0) begin
      x0 = bus.pixel_x; y0 = bus.pixel_y; v0 = bus.pixel_valid; c0 = bus.color_out;
    end
    if (prev_l == VA - 1 && prev_h == HA - 1) begin
      x1 = bus.pixel_x; y1 = bus.pixel_y; v1 = bus.pixel_valid;
    end
    if (prev_l == 0 && prev_h == HA) begin vb = bus.pixel_valid; cb = bus.color_out; end
    prev_l = l; prev_h = h;
  endtask

  task automatic run_lines(input int l0, input int l1, input int long_l);
    int hn;
    for (int l = l0; l < l1; l++) begin
      hn = (l == long_l) ? HT + 1 : HT;
      for (int h = 0; h < hn; h++) send_px(l, h, 1'b0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.pixel_x !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d want=0", bus.pixel_x); end
    checks++; if (bus.pixel_y !== 10'd0) begin failures++; $display("FAIL reset_y got=%0d want=0", bus.pixel_y); end
    checks++; if (bus.color_out !== 8'd0) begin failures++; $display("FAIL reset_color got=%h want=00", bus.color_out); end
    checks++;
    if ({bus.pixel_valid, bus.frame_start, bus.locked, bus.h_err, bus.v_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.pixel_valid, bus.frame_start, bus.locked, bus.h_err, bus.v_err});
    end
  endtask

  task automatic test_lock();
    clear_counts();
    run_lines(0, VT, -1);
    run_lines(0, VT, -1);
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL lock_early got=%b want=0", bus.locked); end
    run_lines(0, VT, -1);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL lock_3rd got=%b want=1", bus.locked); end
    checks++;
    if (lock_l != VSB || lock_h != 0) begin
      failures++; $display("FAIL lock_time got=line%0d/px%0d want=line%0d/px0", lock_l, lock_h, VSB);
    end
    checks++; if (n_fs != 3) begin failures++; $display("FAIL lock_fs got=%0d want=3", n_fs); end
    checks++; if (n_herr != 0 || n_verr != 0) begin failures++; $display("FAIL lock_errs got=%0d/%0d want=0/0", n_herr, n_verr); end
  endtask

  task automatic test_pixels();
    clear_counts();
    x0 = 'x; y0 = 'x; v0 = 'x; c0 = 'x; x1 = 'x; y1 = 'x; v1 = 'x; vb = 'x; cb = 'x;
    run_lines(0, VT, -1);
    checks++; if (x0 !== 10'd0 || y0 !== 10'd0) begin failures++; $display("FAIL first_xy got=%0d,%0d want=0,0", x0, y0); end
    checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL first_valid got=%b want=1", v0); end
    checks++; if (c0 !== 8'b111_000_11) begin failures++; $display("FAIL color_pack got=%b want=11100011", c0); end
    checks++;
    if (x1 !== 10'(HA - 1) || y1 !== 10'(VA - 1)) begin
      failures++; $display("FAIL last_xy got=%0d,%0d want=%0d,%0d", x1, y1, HA - 1, VA - 1);
    end
    checks++; if (v1 !== 1'b1) begin failures++; $display("FAIL last_valid got=%b want=1", v1); end
    checks++; if (vb !== 1'b0 || cb !== 8'd0) begin failures++; $display("FAIL blank_px got=%b/%h want=0/00", vb, cb); end
    checks++; if (n_herr != 0 || n_verr != 0) begin failures++; $display("FAIL pix_errs got=%0d/%0d want=0/0", n_herr, n_verr); end
  endtask

  task automatic test_long_line();
    clear_counts();
    run_lines(0, VT, 5);
    checks++; if (n_herr != 1) begin failures++; $display("FAIL long_herr got=%0d want=1", n_herr); end
    checks++; if (herr_lk !== 1'b0) begin failures++; $display("FAIL long_lockdrop got=%b want=0", herr_lk); end
    checks++; if (n_verr != 0) begin failures++; $display("FAIL long_verr got=%0d want=0", n_verr); end
    run_lines(0, VT, -1);
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL long_relock1 got=%b want=0", bus.locked); end
    run_lines(0, VT, -1);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL long_relock2 got=%b want=1", bus.locked); end
  endtask

  task automatic test_short_frame();
    clear_counts();
    run_lines(0, VT - 1, -1);
    run_lines(0, VT, -1);
    checks++; if (n_verr != 1) begin failures++; $display("FAIL short_verr got=%0d want=1", n_verr); end
    checks++; if (verr_lk !== 1'b0) begin failures++; $display("FAIL short_lockdrop got=%b want=0", verr_lk); end
    checks++; if (n_herr != 0) begin failures++; $display("FAIL short_herr got=%0d want=0", n_herr); end
    run_lines(0, VT, -1);
    checks++; if (bus.locked !== 1'b0) begin failures++; $display("FAIL short_relock1 got=%b want=0", bus.locked); end
    run_lines(0, VT, -1);
    checks++; if (bus.locked !== 1'b1) begin failures++; $display("FAIL short_relock2 got=%b want=1", bus.locked); end
  endtask

  task automatic test_reset_mid();
    clear_counts();
    run_lines(0, 5, -1);
    for (int h = 0; h < 10; h++) send_px(5, h, 1'b0);
    checks++;
    if (bus.locked !== 1'b1 || bus.pixel_x !== 10'd8 || bus.pixel_y !== 10'd5) begin
      failures++; $display("FAIL pre_rst got=lk%b x%0d y%0d want=lk1 x8 y5", bus.locked, bus.pixel_x, bus.pixel_y);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.pixel_x, bus.pixel_y, bus.color_out} !== 28'd0) begin
      failures++; $display("FAIL midrst_data got=%0d,%0d,%h want=0,0,00", bus.pixel_x, bus.pixel_y, bus.color_out);
    end
    checks++;
    if ({bus.pixel_valid, bus.frame_start, bus.locked, bus.h_err, bus.v_err} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_flags got=%b want=00000",
               {bus.pixel_valid, bus.frame_start, bus.locked, bus.h_err, bus.v_err});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_counts();
    for (int h = 10; h < HT; h++) send_px(5, h, 1'b0);
    run_lines(6, VT, -1);
    checks++; if (n_fs != 1) begin failures++; $display("FAIL midrst_fs got=%0d want=1", n_fs); end
    checks++; if (n_verr != 0 || n_herr != 0) begin failures++; $display("FAIL midrst_errs got=%0d/%0d want=0/0", n_verr, n_herr); end
  endtask

  task automatic test_hsync_stuck();
    clear_counts();
    for (int h = 0; h < HSB; h++) send_px(0, h, 1'b0);
    for (int k = 0; k < 1400; k++) send_px(0, HSB, 1'b1);
    checks++; if (n_herr != 1) begin failures++; $display("FAIL stuck_herr got=%0d want=1", n_herr); end
    checks++; if (bus.h_err !== 1'b0 || n_verr != 0) begin failures++; $display("FAIL stuck_tail got=%b/%0d want=0/0", bus.h_err, n_verr); end
  endtask

  initial begin
    bus.pix_en = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1; bus.blank_n = 1'b0;
    bus.red = 8'h00; bus.green = 8'h00; bus.blue = 8'h00;
    test_reset();
    test_lock();
    test_pixels();
    test_long_line();
    test_short_frame();
    test_reset_mid();
    test_hsync_stuck();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_rx_decoder.md
# vga_rx_decoder

Receive-side companion to the game's VGA timing generator. It samples the hsync, vsync, blank and RGB outputs on the system clock, at a pixel-rate strobe. From those it recovers the pixel coordinates and the 8-bit packed colour, checks the horizontal and vertical timing against the 640x480 parameters, and reports lock. It sits next to the display path as an on-chip frame checker, and feeds capture or self-test logic that compares drawn pixels against expected paddle, ball and brick positions.

## Interface
Parameters:
- H_TOTAL, 800: pixel strobes per line
- H_SYNC, 96: hsync low width in strobes
- V_TOTAL, 525: lines per frame
- V_SYNC, 2: vsync low width in lines
- LOCK_FRAMES, 2: consecutive error-free frames required to lock

Ports:
- clk  in  1: system clock; the only clock
- rst  in  1: asynchronous reset, active-high
- pix_en  in  1: one-clk pixel strobe; all sampling and counting happen only on clk edges with pix_en=1
- hsync  in  1: horizontal sync, active-low
- vsync  in  1: vertical sync, active-low
- blank_n  in  1: high = active video
- red, green, blue  in  8 each: pixel colour
- pixel_x  out  10: active-pixel column of the current output sample
- pixel_y  out  10: active-line row of the current output sample
- color_out  out  8: {red[7:5], green[7:5], blue[7:6]}
- pixel_valid  out  1: output sample is active video and the block is locked
- frame_start  out  1: one-strobe pulse on the vsync falling edge
- locked  out  1: timing lock achieved
- h_err  out  1: one-strobe pulse on a bad line period or bad hsync width
- v_err  out  1: one-strobe pulse on a bad frame line count or bad vsync width

## Operation
- Stage 1 registers all inputs. Edge detection and counting compare stage 1 against its previous value.
- h_cnt (10b)
  - Clears to 0 on the hsync falling edge; otherwise increments, saturating at 1023.
  - At each hsync fall, h_cnt+1 must equal H_TOTAL, else h_err.
  - The hsync low run length is checked at the hsync rising edge; it must equal H_SYNC, else h_err.
  - The first hsync fall after reset or after SEARCH is not period-checked.
- Line timeout: if h_cnt saturates, raise h_err once and hold it until the next hsync fall.
- v_cnt (10b)
  - Increments on each hsync fall, saturating.
  - Clears on the vsync falling edge.
  - At each vsync fall, v_cnt must equal V_TOTAL, else v_err.
  - The vsync low width, counted in hsync falls while vsync is low, must equal V_SYNC at the vsync rise, else v_err.
- pixel_x
  - Clears on hsync fall.
  - Holds the column of the current active sample, then increments after each sample with blank_n=1, saturating at 1023.
- pixel_y
  - Clears on vsync fall.
  - Increments at an hsync fall if the line just ended contained at least one active sample.
- State machine:
  - SEARCH (reset state): wait for the first vsync fall, then go to MEASURE with good=0.
  - MEASURE: at each vsync fall with no error during the frame, good++. When good reaches LOCK_FRAMES, go to LOCKED. Any h_err or v_err clears good to 0.
  - LOCKED: locked=1. Any h_err or v_err goes to MEASURE with good=0, and locked drops on that same edge.
- pixel_valid = stage-1 blank_n AND (state == LOCKED).
- A simultaneous hsync and vsync fall in the same strobe is legal. v_cnt is checked and cleared; the hsync does not add to the new frame.

## Timing
- Reset values:
  - pixel_x=0, pixel_y=0, color_out=0
  - pixel_valid, frame_start, locked, h_err, v_err = 0
  - all counters 0, state SEARCH
- Latency: an input sampled at strobe k appears on the outputs after strobe k+1, registered. Outputs hold between strobes.
- Pulse width: frame_start, h_err and v_err are each high for exactly one strobe, from one pix_en edge to the next pix_en edge.
- Lock time: with clean input, locked rises at the (LOCK_FRAMES+1)th vsync fall after reset (the first fall only enters MEASURE). That is the 3rd fall at defaults, plus 1 strobe of output latency.
- Reset mid-frame: everything returns to SEARCH immediately and asynchronously. The partial frame after reset is not error-checked.
- pix_en=0: no state changes anywhere.

## Test plan
- Clean 800x525 stream, pix_en every other clk:
  - locked=1 after the 3rd vsync fall.
  - No h_err or v_err.
  - First active pixel reads pixel_x=0, pixel_y=0.
  - Last active pixel reads 639,479.
- Colour pack: red=8'hE0, green=8'h1F, blue=8'hC0 in active video -> color_out=8'b111_000_11, pixel_valid=1.
- One line of 801 strobes while locked:
  - one h_err pulse at that line's end;
  - locked drops;
  - relock after 2 further clean frames.
- Frame of 524 lines: v_err at the vsync fall, good counter cleared, locked stays 0 through the next clean frame.
- hsync held low indefinitely: h_cnt saturates, a single h_err pulse, no wrap to 0.
- rst asserted mid-frame for 1 clk: all outputs 0 immediately; the next vsync fall gives frame_start with no v_err.
